// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth multiplier sequencer: init/load/shift strobes, add/sub select, iteration count.
// Optional abort input is enabled by defining BOOTH_SEQ_ABORT_EN.
module booth_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q_lsb,
  input  logic       q_prev,
`ifdef BOOTH_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       init,
  output logic [1:0] alu_op,
  output logic       load,
  output logic       shift,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_EVAL  = 3'd2,
    S_LOAD  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  state_t             r_state;
  state_t             w_nxt_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic [1:0]         r_op;
  logic [1:0]         w_nxt_op;
  logic               r_init;
  logic [1:0]         r_alu_op;
  logic               r_load;
  logic               r_shift;
  logic               r_busy;
  logic               r_done;

  // Next-state, counter and operation select
  always_comb begin
    w_nxt_state = S_IDLE;
    w_nxt_cnt   = r_cnt;
    w_nxt_op    = r_op;
    case (r_state)
      S_IDLE:  w_nxt_state = start ? S_INIT : S_IDLE;
      S_INIT: begin
        w_nxt_cnt   = CNT_W'(WIDTH);
        w_nxt_state = S_EVAL;
      end
      S_EVAL: begin
        case ({q_lsb, q_prev})
          2'b10: begin
            w_nxt_op    = OP_SUB;
            w_nxt_state = S_LOAD;
          end
          2'b01: begin
            w_nxt_op    = OP_ADD;
            w_nxt_state = S_LOAD;
          end
          default: begin
            w_nxt_op    = OP_NONE;
            w_nxt_state = S_SHIFT;
          end
        endcase
      end
      S_LOAD:  w_nxt_state = S_SHIFT;
      S_SHIFT: begin
        w_nxt_cnt   = r_cnt - CNT_W'(1);
        w_nxt_state = (r_cnt == CNT_W'(1)) ? S_DONE : S_EVAL;
      end
      S_DONE: begin
        w_nxt_op    = OP_NONE;
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_op    = OP_NONE;
        w_nxt_state = S_IDLE;
      end
    endcase
`ifdef BOOTH_SEQ_ABORT_EN
    // Abort overrides every busy-state transition; the current strobe is already registered
    if (abort && (r_state != S_IDLE)) begin
      w_nxt_state = S_IDLE;
      w_nxt_op    = OP_NONE;
    end
`endif
  end

  // State, counter and outputs registered from the next state so reset clears outputs at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_NONE;
      r_init   <= 1'b0;
      r_alu_op <= OP_NONE;
      r_load   <= 1'b0;
      r_shift  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_op     <= w_nxt_op;
      r_init   <= (w_nxt_state == S_INIT);
      r_alu_op <= (w_nxt_state == S_LOAD) ? w_nxt_op : OP_NONE;
      r_load   <= (w_nxt_state == S_LOAD);
      r_shift  <= (w_nxt_state == S_SHIFT);
      r_busy   <= (w_nxt_state != S_IDLE);
      r_done   <= (w_nxt_state == S_DONE);
    end
  end

  assign init   = r_init;
  assign alu_op = r_alu_op;
  assign load   = r_load;
  assign shift  = r_shift;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: per-cycle strobe trace and product scoreboards, with a behavioural
// A/Q/Q0 datapath for closed-loop multiplies. Abort test runs when BOOTH_SEQ_ABORT_EN is defined.
module tb_booth_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       q_lsb;
  logic       q_prev;
  logic       init;
  logic [1:0] alu_op;
  logic       load;
  logic       shift;
  logic       busy;
  logic       done;
`ifdef BOOTH_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic       tie_mode = 1'b1;
  logic [1:0] tie_val  = 2'b00;
  logic [3:0] tb_m     = 4'd0;
  logic [3:0] tb_mq    = 4'd0;
  logic [3:0] dp_a     = 4'd0;
  logic [3:0] dp_q     = 4'd0;
  logic       dp_q0    = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;
  int n_pop  = 0;

  logic [6:0] q_trace[$];
  logic [7:0] q_prod[$];

  booth_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .q_lsb  (q_lsb),
    .q_prev (q_prev),
`ifdef BOOTH_SEQ_ABORT_EN
    .abort  (abort),
`endif
    .init   (init),
    .alu_op (alu_op),
    .load   (load),
    .shift  (shift),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  assign q_lsb  = tie_mode ? tie_val[1] : dp_q[0];
  assign q_prev = tie_mode ? tie_val[0] : dp_q0;

  // Reference datapath: {A,Q,Q0} register with A+/-M adder
  always @(posedge clk) begin
    if (init) begin
      dp_a  <= 4'd0;
      dp_q  <= tb_mq;
      dp_q0 <= 1'b0;
    end else if (load) begin
      if (alu_op == 2'b01)      dp_a <= dp_a + tb_m;
      else if (alu_op == 2'b10) dp_a <= dp_a - tb_m;
    end else if (shift) begin
      dp_a  <= {dp_a[3], dp_a[3:1]};
      dp_q  <= {dp_a[0], dp_q[3:1]};
      dp_q0 <= dp_q[0];
    end
  end

  // Trace vector layout: {busy, init, load, shift, done, alu_op}
  function automatic logic [6:0] ev(input logic b, input logic i, input logic l,
                                    input logic s, input logic d, input logic [1:0] op);
    return {b, i, l, s, d, op};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Monitor: one trace entry per cycle while queued, one product per done pulse
  always @(negedge clk) begin
    if (q_trace.size() > 0) begin
      logic [6:0] exp_v;
      exp_v = q_trace.pop_front();
      n_pop++;
      check($sformatf("trace#%0d", n_pop), {1'b0, busy, init, load, shift, done, alu_op},
            {1'b0, exp_v});
    end
    if (done && q_prod.size() > 0) begin
      logic [7:0] exp_p;
      exp_p = q_prod.pop_front();
      check("product", {dp_a, dp_q}, exp_p);
    end
  end

  // Expected cycles 1..N of one multiply: INIT, per-iteration EVAL[,LOAD],SHIFT, DONE, IDLE
  task automatic push_run(input logic [3:0] sub_mask, input logic [3:0] add_mask);
    q_trace.push_back(ev(1, 1, 0, 0, 0, 2'b00));
    for (int i = 0; i < 4; i++) begin
      q_trace.push_back(ev(1, 0, 0, 0, 0, 2'b00));
      if (sub_mask[i])      q_trace.push_back(ev(1, 0, 1, 0, 0, 2'b10));
      else if (add_mask[i]) q_trace.push_back(ev(1, 0, 1, 0, 0, 2'b01));
      q_trace.push_back(ev(1, 0, 0, 1, 0, 2'b00));
    end
    q_trace.push_back(ev(1, 0, 0, 0, 1, 2'b00));
    q_trace.push_back(7'd0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (q_trace.size() == 0 && q_prod.size() == 0) break;
      @(posedge clk);
    end
    if (q_trace.size() != 0 || q_prod.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: trace left %0d, products left %0d, required 0 and 0",
               q_trace.size(), q_prod.size());
      q_trace.delete();
      q_prod.delete();
    end
    @(posedge clk);
  endtask

  // Raise start so edge 0 samples it; returns 1 time unit after edge 0 with start still high
  task automatic start_edge();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mult(input logic [3:0] m, input logic [3:0] q,
                          input logic [3:0] sub_mask, input logic [3:0] add_mask,
                          input logic [7:0] exp_p);
    tie_mode = 1'b0;
    tb_m     = m;
    tb_mq    = q;
    start_edge();
    start = 1'b0;
    push_run(sub_mask, add_mask);
    q_prod.push_back(exp_p);
    wait_drain();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    q_trace.push_back(7'd0);
    q_trace.push_back(7'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    q_trace.push_back(7'd0);
    q_trace.push_back(7'd0);
    wait_drain();

    // Q bits tied 00: shifts only, done in cycle 10
    tie_mode = 1'b1;
    tie_val  = 2'b00;
    start_edge();
    start = 1'b0;
    push_run(4'b0000, 4'b0000);
    wait_drain();

    // Q bits tied 10: subtract every iteration, done in cycle 14
    tie_val = 2'b10;
    start_edge();
    start = 1'b0;
    push_run(4'b1111, 4'b0000);
    wait_drain();

    // Closed loop: 3 * -2 = -6, then -7 * -7 = 49
    run_mult(4'b0011, 4'b1110, 4'b0010, 4'b0000, 8'hFA);
    run_mult(4'b1001, 4'b1001, 4'b1001, 4'b0010, 8'h31);

    // start re-pulsed in cycles 3 and 6 is ignored
    tie_mode = 1'b1;
    tie_val  = 2'b00;
    start_edge();
    start = 1'b0;
    push_run(4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain();

    // start held high: second INIT two cycles after DONE
    start_edge();
    push_run(4'b0000, 4'b0000);
    push_run(4'b0000, 4'b0000);
    repeat (11) @(posedge clk);
    #1 start = 1'b0;
    wait_drain();

    // Reset asserted mid-LOAD drops outputs before the next edge, no done
    tie_val = 2'b10;
    start_edge();
    start = 1'b0;
    q_trace.push_back(ev(1, 1, 0, 0, 0, 2'b00));
    q_trace.push_back(ev(1, 0, 0, 0, 0, 2'b00));
    q_trace.push_back(7'd0);
    q_trace.push_back(7'd0);
    q_trace.push_back(7'd0);
    repeat (2) @(posedge clk);
    #1 check("load_before_rst", {4'd0, load, alu_op, busy}, 8'b0000_1101);
    #1 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    wait_drain();
    run_mult(4'b0011, 4'b1110, 4'b0010, 4'b0000, 8'hFA);

`ifdef BOOTH_SEQ_ABORT_EN
    // abort sampled at the end of cycle 5 returns to IDLE in cycle 6
    tie_mode = 1'b1;
    tie_val  = 2'b00;
    start_edge();
    start = 1'b0;
    q_trace.push_back(ev(1, 1, 0, 0, 0, 2'b00));
    q_trace.push_back(ev(1, 0, 0, 0, 0, 2'b00));
    q_trace.push_back(ev(1, 0, 0, 1, 0, 2'b00));
    q_trace.push_back(ev(1, 0, 0, 0, 0, 2'b00));
    q_trace.push_back(ev(1, 0, 0, 1, 0, 2'b00));
    q_trace.push_back(7'd0);
    q_trace.push_back(7'd0);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_drain();
    run_mult(4'b1001, 4'b1001, 4'b1001, 4'b0010, 8'h31);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1);
  end

endmodule
